// File: rtl/ttl_encoder_4to2_dual_latched_if.sv
// Line bank / result bus between a set of active-low line groups and the
// encoder that latches them. The encoder is the slave; whoever drives the
// lines and consumes the result is the master.
interface ttl_encoder_4to2_dual_latched_if #(
    parameter int unsigned BLOCKS    = 2,
    parameter int unsigned WIDTH_IN  = 4,
    parameter int unsigned WIDTH_OUT = $clog2(WIDTH_IN)
);
    logic [BLOCKS-1:0]           Enable_bar;
    logic [BLOCKS*WIDTH_IN-1:0]  D_2D;
    logic [BLOCKS-1:0]           Ack;
    logic [BLOCKS*WIDTH_OUT-1:0] A_2D;
    logic [BLOCKS-1:0]           Valid;
    logic [BLOCKS-1:0]           Multiple;
    logic [BLOCKS-1:0]           Overrun;

    modport master (
        output Enable_bar,
        output D_2D,
        output Ack,
        input  A_2D,
        input  Valid,
        input  Multiple,
        input  Overrun
    );

    modport slave (
        input  Enable_bar,
        input  D_2D,
        input  Ack,
        output A_2D,
        output Valid,
        output Multiple,
        output Overrun
    );
endinterface

// File: rtl/ttl_encoder_4to2_dual_latched.sv
// Dual 4-line to 2-line priority encoder with qualified, latched outputs.
// Each block debounces its active-low line group, encodes the highest low
// line, holds the result until acknowledged, then waits for the lines to be
// released before it can arm again (one event per press).
module ttl_encoder_4to2_dual_latched #(
    parameter int unsigned BLOCKS        = 2,
    parameter int unsigned WIDTH_IN      = 4,
    parameter int unsigned WIDTH_OUT     = $clog2(WIDTH_IN),
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned DELAY_RISE    = 0,
    parameter int unsigned DELAY_FALL    = 0
) (
    input  logic                           Clk,
    input  logic                           Clear_bar,
    ttl_encoder_4to2_dual_latched_if.slave bus
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUALIFY,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    // Rise/fall delays of the original part are not modelled: outputs come
    // straight from flops, so there is nothing to delay in synthesis.
    if (DELAY_RISE != 0 || DELAY_FALL != 0) begin : g_delay_unmodelled
    end

    logic [BLOCKS*WIDTH_OUT-1:0] a_all;
    logic [BLOCKS-1:0]           valid_all;
    logic [BLOCKS-1:0]           mult_all;
    logic [BLOCKS-1:0]           ovr_all;

    for (genvar b = 0; b < BLOCKS; b++) begin : g_block
        logic [WIDTH_IN-1:0]  lines;
        logic [WIDTH_IN-1:0]  low;
        logic                 any_low;
        logic                 active;
        logic                 multi;
        logic [WIDTH_OUT-1:0] code;

        state_t               state_q, state_d;
        logic [CW-1:0]        count_q, count_d;
        logic [CW-1:0]        count_inc;
        logic [WIDTH_OUT-1:0] code_q, code_d;
        logic [WIDTH_OUT-1:0] a_q, a_d;
        logic                 valid_q, valid_d;
        logic                 mult_q, mult_d;
        logic                 ovr_q, ovr_d;

        assign lines     = bus.D_2D[b*WIDTH_IN +: WIDTH_IN];
        assign low       = ~lines;
        assign any_low   = |low;
        assign active    = ~bus.Enable_bar[b] & any_low;
        assign multi     = (low & (low - WIDTH_IN'(1))) != '0;
        assign count_inc = count_q + CW'(1);

        // Priority encode: later (higher) indices override earlier ones.
        always_comb begin
            code = '0;
            for (int unsigned i = 0; i < WIDTH_IN; i++) begin
                if (low[i]) begin
                    code = WIDTH_OUT'(i);
                end
            end
        end

        // State and output registers with synchronous active-low clear.
        always_ff @(posedge Clk) begin
            if (!Clear_bar) begin
                state_q <= ST_IDLE;
                count_q <= '0;
                code_q  <= '0;
                a_q     <= '0;
                valid_q <= 1'b0;
                mult_q  <= 1'b0;
                ovr_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                code_q  <= code_d;
                a_q     <= a_d;
                valid_q <= valid_d;
                mult_q  <= mult_d;
                ovr_q   <= ovr_d;
            end
        end

        // Qualify/hold/release sequencing and next output values.
        always_comb begin
            state_d = state_q;
            count_d = count_q;
            code_d  = code_q;
            a_d     = a_q;
            valid_d = valid_q;
            mult_d  = mult_q;
            ovr_d   = ovr_q;

            case (state_q)
                ST_IDLE: begin
                    if (active) begin
                        code_d  = code;
                        count_d = CW'(1);
                        if (STABLE_CYCLES == 1) begin
                            state_d = ST_HOLD;
                            a_d     = code;
                            valid_d = 1'b1;
                            mult_d  = multi;
                            ovr_d   = 1'b0;
                        end else begin
                            state_d = ST_QUALIFY;
                        end
                    end
                end

                ST_QUALIFY: begin
                    if (!active) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end else if (code == code_q) begin
                        count_d = count_inc;
                        if (count_inc == STABLE_C) begin
                            state_d = ST_HOLD;
                            a_d     = code_q;
                            valid_d = 1'b1;
                            mult_d  = multi;
                            ovr_d   = 1'b0;
                        end
                    end else begin
                        code_d  = code;
                        count_d = CW'(1);
                    end
                end

                // Enable is ignored here so a held result cannot be lost.
                ST_HOLD: begin
                    if (bus.Ack[b]) begin
                        state_d = ST_RELEASE;
                        count_d = '0;
                        valid_d = 1'b0;
                        ovr_d   = 1'b0;
                    end else if (any_low && (code != a_q)) begin
                        ovr_d = 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (active) begin
                        count_d = '0;
                    end else if (count_inc == STABLE_C) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_inc;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end

        assign a_all[b*WIDTH_OUT +: WIDTH_OUT] = a_q;
        assign valid_all[b]                    = valid_q;
        assign mult_all[b]                     = mult_q;
        assign ovr_all[b]                      = ovr_q;
    end

    assign bus.A_2D     = a_all;
    assign bus.Valid    = valid_all;
    assign bus.Multiple = mult_all;
    assign bus.Overrun  = ovr_all;

endmodule

// File: tb/tb_ttl_encoder_4to2_dual_latched.sv
// Directed bench for the dual latched priority encoder. Each step drives one
// cycle of inputs, queues the outputs expected after the next rising edge,
// then pops and compares them shortly after that edge.
module tb_ttl_encoder_4to2_dual_latched;

    logic Clk = 1'b0;
    logic Clear_bar;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];

    ttl_encoder_4to2_dual_latched_if #(
        .BLOCKS   (2),
        .WIDTH_IN (4),
        .WIDTH_OUT(2)
    ) bus ();

    ttl_encoder_4to2_dual_latched #(
        .BLOCKS       (2),
        .WIDTH_IN     (4),
        .WIDTH_OUT    (2),
        .STABLE_CYCLES(2),
        .DELAY_RISE   (0),
        .DELAY_FALL   (0)
    ) dut (
        .Clk      (Clk),
        .Clear_bar(Clear_bar),
        .bus      (bus)
    );

    always #5 Clk = ~Clk;

    // One clock step: drive, queue expectation {A_2D, Valid, Multiple, Overrun},
    // wait past the edge, then compare against the DUT.
    task automatic step(input string tag, input logic clr, input logic [1:0] en,
                        input logic [7:0] d, input logic [1:0] ack,
                        input logic [3:0] exp_a, input logic [1:0] exp_v,
                        input logic [1:0] exp_m, input logic [1:0] exp_o);
        sb_entry_t  e;
        logic [9:0] obs;
        Clear_bar      = clr;
        bus.Enable_bar = en;
        bus.D_2D       = d;
        bus.Ack        = ack;
        sb.push_back('{tag, {exp_a, exp_v, exp_m, exp_o}});
        @(posedge Clk);
        #1;
        e   = sb.pop_front();
        obs = {bus.A_2D, bus.Valid, bus.Multiple, bus.Overrun};
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed A/V/M/O=%b expected=%b", e.tag, obs, e.exp);
        end
    endtask

    initial begin
        Clear_bar      = 1'b0;
        bus.Enable_bar = 2'b00;
        bus.D_2D       = 8'h00;
        bus.Ack        = 2'b00;
        @(negedge Clk);

        //    tag            clr  en     d      ack    A        V      M      O
        step("rst0",         0, 2'b00, 8'h00, 2'b11, 4'b0000, 2'b00, 2'b00, 2'b00);
        step("rst1",         0, 2'b00, 8'h00, 2'b11, 4'b0000, 2'b00, 2'b00, 2'b00);
        step("idle_ff",      1, 2'b00, 8'hFF, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00);
        step("idle_ff2",     1, 2'b00, 8'hFF, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00);

        // block0 line 2: qualifies after two samples
        step("press_q",      1, 2'b00, 8'hFB, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00);
        step("press_hold",   1, 2'b00, 8'hFB, 2'b00, 4'b0010, 2'b01, 2'b00, 2'b00);
        step("hold_keep",    1, 2'b00, 8'hFB, 2'b00, 4'b0010, 2'b01, 2'b00, 2'b00);
        step("ack0",         1, 2'b00, 8'hFB, 2'b01, 4'b0010, 2'b00, 2'b00, 2'b00);
        step("rel_low",      1, 2'b00, 8'hFB, 2'b00, 4'b0010, 2'b00, 2'b00, 2'b00);
        step("rel_hi1",      1, 2'b00, 8'hFF, 2'b00, 4'b0010, 2'b00, 2'b00, 2'b00);
        step("rel_hi2",      1, 2'b00, 8'hFF, 2'b00, 4'b0010, 2'b00, 2'b00, 2'b00);

        // block1 lines 1 and 3 together: priority to 3, Multiple set
        step("mult_q",       1, 2'b00, 8'h5F, 2'b00, 4'b0010, 2'b00, 2'b00, 2'b00);
        step("mult_hold",    1, 2'b00, 8'h5F, 2'b00, 4'b1110, 2'b10, 2'b10, 2'b00);
        step("mult_ack",     1, 2'b00, 8'hFF, 2'b10, 4'b1110, 2'b00, 2'b10, 2'b00);
        step("b1_rel1",      1, 2'b00, 8'hFF, 2'b00, 4'b1110, 2'b00, 2'b10, 2'b00);
        step("b1_rel2",      1, 2'b00, 8'hFF, 2'b00, 4'b1110, 2'b00, 2'b10, 2'b00);

        // single-sample glitch on block0 line 0 is rejected
        step("glitch",       1, 2'b00, 8'hFE, 2'b00, 4'b1110, 2'b00, 2'b10, 2'b00);
        step("glitch_end",   1, 2'b00, 8'hFF, 2'b00, 4'b1110, 2'b00, 2'b10, 2'b00);
        step("glitch_quiet", 1, 2'b00, 8'hFF, 2'b00, 4'b1110, 2'b00, 2'b10, 2'b00);

        // overrun while held, ack clears it, held line does not re-trigger
        step("ov_q",         1, 2'b00, 8'hFB, 2'b00, 4'b1110, 2'b00, 2'b10, 2'b00);
        step("ov_hold",      1, 2'b00, 8'hFB, 2'b00, 4'b1110, 2'b01, 2'b10, 2'b00);
        step("ov_set",       1, 2'b00, 8'hFD, 2'b00, 4'b1110, 2'b01, 2'b10, 2'b01);
        step("ov_sticky",    1, 2'b00, 8'hFB, 2'b00, 4'b1110, 2'b01, 2'b10, 2'b01);
        step("ov_ack",       1, 2'b00, 8'hFD, 2'b01, 4'b1110, 2'b00, 2'b10, 2'b00);
        step("retrig1",      1, 2'b00, 8'hFD, 2'b00, 4'b1110, 2'b00, 2'b10, 2'b00);
        step("retrig2",      1, 2'b00, 8'hFD, 2'b00, 4'b1110, 2'b00, 2'b10, 2'b00);
        step("rearm_rel1",   1, 2'b00, 8'hFF, 2'b00, 4'b1110, 2'b00, 2'b10, 2'b00);
        step("rearm_rel2",   1, 2'b00, 8'hFF, 2'b00, 4'b1110, 2'b00, 2'b10, 2'b00);
        step("rearm_q",      1, 2'b00, 8'hFD, 2'b00, 4'b1110, 2'b00, 2'b10, 2'b00);
        step("rearm_hold",   1, 2'b00, 8'hFD, 2'b00, 4'b1101, 2'b01, 2'b10, 2'b00);

        // enable ignored while held, then reset mid-hold
        step("en_hold",      1, 2'b01, 8'hFF, 2'b00, 4'b1101, 2'b01, 2'b10, 2'b00);
        step("en_hold2",     1, 2'b01, 8'hFD, 2'b00, 4'b1101, 2'b01, 2'b10, 2'b00);
        step("rst_hold",     0, 2'b00, 8'hFD, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00);

        // disabled block never presses
        step("dis_1",        1, 2'b01, 8'hF7, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00);
        step("dis_2",        1, 2'b01, 8'hF7, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00);
        step("dis_3",        1, 2'b01, 8'hF7, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00);

        // reset mid-qualify restarts the count
        step("q_start",      1, 2'b00, 8'hF7, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00);
        step("q_rst",        0, 2'b00, 8'hF7, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00);
        step("q_after",      1, 2'b00, 8'hF7, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00);
        step("q_hold",       1, 2'b00, 8'hF7, 2'b00, 4'b0011, 2'b01, 2'b00, 2'b00);

        // blocks independent: block1 qualifies while block0 holds
        step("both_q",       1, 2'b00, 8'hE7, 2'b00, 4'b0011, 2'b01, 2'b00, 2'b00);
        step("both_hold",    1, 2'b00, 8'hE7, 2'b00, 4'b0011, 2'b11, 2'b00, 2'b00);
        step("both_ack",     1, 2'b00, 8'hFF, 2'b11, 4'b0011, 2'b00, 2'b00, 2'b00);
        step("both_rel1",    1, 2'b00, 8'hFF, 2'b00, 4'b0011, 2'b00, 2'b00, 2'b00);
        step("both_rel2",    1, 2'b00, 8'hFF, 2'b00, 4'b0011, 2'b00, 2'b00, 2'b00);

        // code change during qualify restarts qualification
        step("chg_q",        1, 2'b00, 8'hFB, 2'b00, 4'b0011, 2'b00, 2'b00, 2'b00);
        step("chg_new",      1, 2'b00, 8'hFD, 2'b00, 4'b0011, 2'b00, 2'b00, 2'b00);
        step("chg_hold",     1, 2'b00, 8'hFD, 2'b00, 4'b0001, 2'b01, 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
